bit_reverse_pipe: RTL and testbench

Streaming, parametrised successor to the combinational bit reverser. Applies one of four runtime-selectable permutations per word: full bit reverse, group-order swap, in-group bit reverse, or passthrough. Uses valid/ready handshakes on both sides and a 2-entry output buffer, so upstream and downstream can stall independently. Sits between a producer stream and a consumer stream in datapath test harnesses.

---
 rtl/bit_reverse_pipe_pkg.sv | 15 +
 rtl/bit_reverse_pipe_permute.sv | 41 ++++
 rtl/bit_reverse_pipe.sv | 87 ++++++++
 tb/tb_bit_reverse_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_reverse_pipe_pkg.sv
// Shared types and elaboration-time helpers for the bit_reverse_pipe stream permuter.
package bit_reverse_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_FULL_REV     = 2'd0,
      MODE_GROUP_SWAP   = 2'd1,
      MODE_IN_GROUP_REV = 2'd2,
      MODE_PASS         = 2'd3
   } mode_e;

   function automatic bit width_ok(input int data_width, input int group_width);
      return (group_width > 0) && (data_width >= 2) && ((data_width % group_width) == 0);
   endfunction

endpackage

// File: rtl/bit_reverse_pipe_permute.sv
// Combinational word permuter: full reverse, group-order swap, in-group reverse or passthrough.
module bit_permute
   import bit_reverse_pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int GROUP_WIDTH = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] din,
   input  mode_e                 mode,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int NUM_GROUPS = DATA_WIDTH / GROUP_WIDTH;

   logic [DATA_WIDTH-1:0] full_rev;
   logic [DATA_WIDTH-1:0] grp_swap;
   logic [DATA_WIDTH-1:0] in_grp_rev;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_full
      assign full_rev[i] = din[DATA_WIDTH-1-i];
   end

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      for (genvar b = 0; b < GROUP_WIDTH; b++) begin : g_bit
         assign grp_swap[g*GROUP_WIDTH+b]   = din[(NUM_GROUPS-1-g)*GROUP_WIDTH+b];
         assign in_grp_rev[g*GROUP_WIDTH+b] = din[g*GROUP_WIDTH+GROUP_WIDTH-1-b];
      end
   end

   always_comb begin
      dout = din;
      case (mode)
         MODE_FULL_REV:     dout = full_rev;
         MODE_GROUP_SWAP:   dout = grp_swap;
         MODE_IN_GROUP_REV: dout = in_grp_rev;
         MODE_PASS:         dout = din;
      endcase
   end

endmodule

// File: rtl/bit_reverse_pipe.sv
// Streaming bit permuter with valid/ready on both sides, a 2-entry output buffer and a transfer counter.
module bit_reverse_pipe
   import bit_reverse_pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int GROUP_WIDTH = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [DATA_WIDTH-1:0]  din,
   input  logic [1:0]             mode,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [COUNT_WIDTH-1:0] xfer_count
);

   if (!width_ok(DATA_WIDTH, GROUP_WIDTH)) begin : g_width_err
      $error("bit_reverse_pipe: DATA_WIDTH must be >= 2 and a multiple of GROUP_WIDTH");
   end

   logic [DATA_WIDTH-1:0]  perm_word;
   logic [DATA_WIDTH-1:0]  head_q, head_d;
   logic [DATA_WIDTH-1:0]  tail_q, tail_d;
   logic [1:0]             count_q, count_d;
   logic [COUNT_WIDTH-1:0] xfer_q, xfer_d;
   logic                   push, pop;

   bit_permute #(
      .DATA_WIDTH  (DATA_WIDTH),
      .GROUP_WIDTH (GROUP_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_permute (
      .din  (din),
      .mode (mode_e'(mode)),
      .dout (perm_word)
   );

   assign din_ready  = (count_q != 2'd2);
   assign dout_valid = (count_q != 2'd0);
   assign dout       = head_q;
   assign xfer_count = xfer_q;

   assign push = din_valid && din_ready;
   assign pop  = dout_valid && dout_ready;

   // head_q is the FIFO head and the output register; it is only overwritten when
   // a new word lands there, so dout keeps its last value once the buffer drains.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      xfer_d  = xfer_q;
      case ({push, pop})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) head_d = perm_word;
            else                 tail_d = perm_word;
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            if (count_q == 2'd2) head_d = tail_q;
         end
         2'b11: head_d = perm_word;
         default: ;
      endcase
      if (pop) xfer_d = xfer_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         xfer_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         xfer_q  <= xfer_d;
      end
   end

endmodule

// File: tb/tb_bit_reverse_pipe.sv
// Randomised and directed bench for bit_reverse_pipe against a queue-based reference model.
module tb_bit_reverse_pipe;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] din;
   logic [1:0]  mode;
   logic        din_valid;
   logic        dout_ready;

   logic        din_ready_a, dout_valid_a;
   logic [31:0] dout_a;
   logic [15:0] xfer_a;
   logic        din_ready_c, dout_valid_c;
   logic [31:0] dout_c;
   logic [3:0]  xfer_c;
   logic        din_ready_g, dout_valid_g;
   logic [31:0] dout_g;
   logic [15:0] xfer_g;

   int checks = 0;
   int errors = 0;

   logic [31:0] q8[$];
   logic [31:0] q1[$];
   logic [31:0] last8, last1;
   int          xfers;

   always #5 clk = ~clk;

   bit_reverse_pipe #(.DATA_WIDTH(32), .GROUP_WIDTH(8), .COUNT_WIDTH(16)) dut_a (
      .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
      .din_ready(din_ready_a), .dout(dout_a), .dout_valid(dout_valid_a),
      .dout_ready(dout_ready), .xfer_count(xfer_a));

   bit_reverse_pipe #(.DATA_WIDTH(32), .GROUP_WIDTH(8), .COUNT_WIDTH(4)) dut_c (
      .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
      .din_ready(din_ready_c), .dout(dout_c), .dout_valid(dout_valid_c),
      .dout_ready(dout_ready), .xfer_count(xfer_c));

   bit_reverse_pipe #(.DATA_WIDTH(32), .GROUP_WIDTH(1), .COUNT_WIDTH(16)) dut_g (
      .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
      .din_ready(din_ready_g), .dout(dout_g), .dout_valid(dout_valid_g),
      .dout_ready(dout_ready), .xfer_count(xfer_g));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rev_all(input logic [31:0] w);
      logic [31:0] r = '0;
      for (int i = 0; i < 32; i++) r = (r << 1) | ((w >> i) & 32'd1);
      return r;
   endfunction

   function automatic logic [31:0] swap_groups(input logic [31:0] w, input int gw);
      longint unsigned mask = (64'd1 << gw) - 1;
      longint unsigned r = 0;
      int n = 32 / gw;
      for (int g = 0; g < n; g++) r |= ((longint'(w) >> (g * gw)) & mask) << ((n - 1 - g) * gw);
      return r[31:0];
   endfunction

   // In-group reverse is a full reverse followed by undoing the group reordering.
   function automatic logic [31:0] ref_perm(input logic [31:0] w, input logic [1:0] m, input int gw);
      case (m)
         2'd0:    return rev_all(w);
         2'd1:    return swap_groups(w, gw);
         2'd2:    return swap_groups(rev_all(w), gw);
         default: return w;
      endcase
   endfunction

   task automatic model_reset();
      q8.delete();
      q1.delete();
      last8 = '0;
      last1 = '0;
      xfers = 0;
   endtask

   task automatic compare();
      chk("a_valid", 32'(dout_valid_a), 32'(q8.size() != 0));
      chk("a_ready", 32'(din_ready_a), 32'(q8.size() != 2));
      chk("a_dout", dout_a, (q8.size() != 0) ? q8[0] : last8);
      chk("a_xfer", 32'(xfer_a), 32'(xfers % 65536));
      chk("c_xfer", 32'(xfer_c), 32'(xfers % 16));
      chk("c_ready", 32'(din_ready_c), 32'(q8.size() != 2));
      chk("g_valid", 32'(dout_valid_g), 32'(q1.size() != 0));
      chk("g_dout", dout_g, (q1.size() != 0) ? q1[0] : last1);
   endtask

   task automatic step();
      bit push, pop;
      @(posedge clk);
      push = din_valid && (q8.size() < 2);
      pop  = dout_ready && (q8.size() > 0);
      if (pop) begin
         last8 = q8.pop_front();
         last1 = q1.pop_front();
         xfers++;
      end
      if (push) begin
         q8.push_back(ref_perm(din, mode, 8));
         q1.push_back(ref_perm(din, mode, 1));
      end
      #1 compare();
   endtask

   logic [31:0] vec_din[4]  = '{32'h12345678, 32'h12345678, 32'h01020304, 32'hDEADBEEF};
   logic [1:0]  vec_mode[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
   logic [31:0] vec_exp[4]  = '{32'h1E6A2C48, 32'h78563412, 32'h8040C020, 32'hDEADBEEF};

   initial begin
      int base;
      int n;
      resetn = 1'b0;
      din = '0; mode = '0; din_valid = 1'b0; dout_ready = 1'b0;
      model_reset();
      #12 compare();
      @(negedge clk) resetn = 1'b1;

      // Mode vectors
      dout_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         din = vec_din[k]; mode = vec_mode[k]; din_valid = 1'b1;
         step();
         chk("mode_vec", dout_a, vec_exp[k]);
         chk("mode_vec_valid", 32'(dout_valid_a), 32'd1);
         din_valid = 1'b0;
         step();
      end

      // Back-to-back streaming
      base = xfers;
      for (int k = 0; k < 8; k++) begin
         din = 32'h100 + k; mode = 2'd3; din_valid = 1'b1;
         step();
         chk("stream_ready", 32'(din_ready_a), 32'd1);
      end
      din_valid = 1'b0;
      step();
      chk("stream_xfers", 32'(xfer_a - 16'(base)), 32'd8);

      // Backpressure
      dout_ready = 1'b0; mode = 2'd0; din_valid = 1'b1;
      din = 32'h1; step();
      din = 32'h2; step();
      din = 32'h3; step();
      chk("bp_ready_low", 32'(din_ready_a), 32'd0);
      chk("bp_head", dout_a, 32'h80000000);
      step();
      chk("bp_head_stable", dout_a, 32'h80000000);
      dout_ready = 1'b1;
      step();
      chk("bp_ready_rise", 32'(din_ready_a), 32'd1);
      chk("bp_out2", dout_a, 32'h40000000);
      step();
      chk("bp_out3", dout_a, 32'hC0000000);
      din_valid = 1'b0;
      step();

      // Mode change with a buffered word
      dout_ready = 1'b0; din = 32'h1; mode = 2'd0; din_valid = 1'b1;
      step();
      din_valid = 1'b0; mode = 2'd3; din = 32'hFFFF0000;
      step();
      chk("mode_change_hold", dout_a, 32'h80000000);

      // Reset with a full buffer
      din_valid = 1'b1; din = 32'h5;
      step();
      chk("fill_ready", 32'(din_ready_a), 32'd0);
      #2 resetn = 1'b0;
      model_reset();
      #1 compare();
      chk("rst_ready", 32'(din_ready_a), 32'd1);
      chk("rst_dout", dout_a, 32'd0);
      din_valid = 1'b0;
      @(negedge clk) resetn = 1'b1;
      din = 32'h12345678; mode = 2'd1; din_valid = 1'b1; dout_ready = 1'b1;
      step();
      chk("post_rst_word", dout_a, 32'h78563412);
      chk("post_rst_g1_mode1", dout_g, 32'h1E6A2C48);
      mode = 2'd2;
      step();
      chk("post_rst_g1_mode2", dout_g, 32'h12345678);

      // Counter wrap on the 4-bit instance
      n = 0;
      while (xfers < 15 && n < 100) begin
         din = $urandom; step(); n++;
      end
      chk("wrap_15", 32'(xfer_c), 32'd15);
      step();
      chk("wrap_0", 32'(xfer_c), 32'd0);
      step();
      chk("wrap_1", 32'(xfer_c), 32'd1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         din        = $urandom;
         mode       = 2'($urandom_range(0, 3));
         din_valid  = ($urandom_range(0, 3) != 0);
         dout_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
